// File: rtl/shared_timer_pkg.sv
// rtl/shared_timer_pkg.sv - shared types and timer register map for the timer arbiter
package shared_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  localparam int TMR_STATUS  = 0;
  localparam int TMR_CONTROL = 1;
  localparam int TMR_PERIODL = 2;
  localparam int TMR_PERIODH = 3;
  localparam int TMR_SNAPL   = 4;
  localparam int TMR_SNAPH   = 5;

endpackage

// File: rtl/shared_timer_arbiter_rr_arb2.sv
// rtl/shared_timer_arbiter_rr_arb2.sv - two-way round-robin grant with registered last-winner
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       done_i,
  input  logic       done_idx_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  logic last_grant_q;
  logic last_grant_d;

  // a lone requester wins outright; a tie goes to whoever did not win last
  always_comb begin
    gnt_valid_o = |req_i;
    gnt_idx_o   = 1'b0;
    if (req_i == 2'b11) begin
      gnt_idx_o = ~last_grant_q;
    end else if (req_i[1]) begin
      gnt_idx_o = 1'b1;
    end
  end

  // remember the winner only once its transfer actually completes
  always_comb begin
    last_grant_d = last_grant_q;
    if (done_i) begin
      last_grant_d = done_idx_i;
    end
  end

  // reset to 1 so master 0 takes the first tie
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/shared_timer_arbiter.sv
// rtl/shared_timer_arbiter.sv - shares one timer slave between two masters; optional SHARED_TIMER_IRQ_STEER_EN
module shared_timer_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_waitrequest,
  output logic              m0_irq,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_waitrequest,
  output logic              m1_irq,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_chipselect,
  output logic              s_write_n,
  output logic [DATA_W-1:0] s_writedata,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_irq
);
  import shared_timer_pkg::*;

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic [ADDR_W-1:0]   s_address_q, s_address_d;
  logic [DATA_W-1:0]   s_writedata_q, s_writedata_d;
  logic                s_chipselect_q, s_chipselect_d;
  logic                s_write_n_q, s_write_n_d;
  logic [DATA_W-1:0]   rd0_q, rd0_d;
  logic [DATA_W-1:0]   rd1_q, rd1_d;
  logic                done;
  logic                m0_req, m1_req;
  logic                gnt_valid, gnt_idx;

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

  rr_arb2 u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_i       ({m1_req, m0_req}),
    .done_i      (done),
    .done_idx_i  (grant_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  // transfer sequencer: chipselect is only ever raised for the single ISSUE cycle
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    s_address_d    = s_address_q;
    s_writedata_d  = s_writedata_q;
    s_chipselect_d = 1'b0;
    s_write_n_d    = 1'b1;
    rd0_d          = rd0_q;
    rd1_d          = rd1_q;
    done           = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          grant_d        = gnt_idx;
          s_address_d    = gnt_idx ? m1_address : m0_address;
          s_writedata_d  = gnt_idx ? m1_writedata : m0_writedata;
          s_write_n_d    = gnt_idx ? ~m1_write : ~m0_write;
          s_chipselect_d = 1'b1;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        if (!s_write_n_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        done = 1'b1;
        if (grant_q) begin
          rd1_d = s_readdata;
        end else begin
          rd0_d = s_readdata;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and slave-side registers; reset abandons any transfer in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      grant_q        <= 1'b0;
      s_address_q    <= '0;
      s_writedata_q  <= '0;
      s_chipselect_q <= 1'b0;
      s_write_n_q    <= 1'b1;
      rd0_q          <= '0;
      rd1_q          <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      s_address_q    <= s_address_d;
      s_writedata_q  <= s_writedata_d;
      s_chipselect_q <= s_chipselect_d;
      s_write_n_q    <= s_write_n_d;
      rd0_q          <= rd0_d;
      rd1_q          <= rd1_d;
    end
  end

  assign s_address    = s_address_q;
  assign s_writedata  = s_writedata_q;
  assign s_chipselect = s_chipselect_q;
  assign s_write_n    = s_write_n_q;

  // the timer's data is live during CAPTURE, so the grantee sees it directly that cycle
  assign m0_readdata = (state_q == CAPTURE && !grant_q) ? s_readdata : rd0_q;
  assign m1_readdata = (state_q == CAPTURE &&  grant_q) ? s_readdata : rd1_q;

  assign m0_waitrequest = m0_req & ~(done & ~grant_q);
  assign m1_waitrequest = m1_req & ~(done &  grant_q);

`ifdef SHARED_TIMER_IRQ_STEER_EN
  logic irq_owner_q, irq_owner_d;

  // whoever last wrote the control register owns the interrupt
  always_comb begin
    irq_owner_d = irq_owner_q;
    if (state_q == ISSUE && !s_write_n_q && s_address_q == ADDR_W'(TMR_CONTROL)) begin
      irq_owner_d = grant_q;
    end
  end

  // owner register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_owner_q <= 1'b0;
    end else begin
      irq_owner_q <= irq_owner_d;
    end
  end

  assign m0_irq = s_irq & ~irq_owner_q;
  assign m1_irq = s_irq &  irq_owner_q;
`else
  assign m0_irq = s_irq;
  assign m1_irq = s_irq;
`endif

endmodule

// File: tb/tb_shared_timer_arbiter.sv
// tb/tb_shared_timer_arbiter.sv - randomized self-checking bench for shared_timer_arbiter
module tb_shared_timer_arbiter;

  localparam int AW = 3;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] m_addr [2];
  logic          m_rd   [2];
  logic          m_wr   [2];
  logic [DW-1:0] m_wd   [2];
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_waitrequest, m1_waitrequest, m0_irq, m1_irq;
  logic [AW-1:0] s_address;
  logic          s_chipselect, s_write_n;
  logic [DW-1:0] s_writedata;
  logic [DW-1:0] s_readdata;
  logic          s_irq = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ref_mem [8];
  logic [DW-1:0] last_rd [2];
  int order [$];
  logic prev_cs = 1'b0;
  int cs_count = 0;
  int snap_count = 0;

  always #5 clk = ~clk;

  shared_timer_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m_addr[0]), .m0_read(m_rd[0]), .m0_write(m_wr[0]), .m0_writedata(m_wd[0]),
    .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest), .m0_irq(m0_irq),
    .m1_address(m_addr[1]), .m1_read(m_rd[1]), .m1_write(m_wr[1]), .m1_writedata(m_wd[1]),
    .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest), .m1_irq(m1_irq),
    .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
    .s_writedata(s_writedata), .s_readdata(s_readdata), .s_irq(s_irq)
  );

  function automatic logic [DW-1:0] seed(input int i);
    return DW'(16'h0002 + 16'h1111 * i);
  endfunction

  // timer slave model: registers 0..5, addresses 6/7 read as zero, readdata one cycle late
  logic [DW-1:0] tmr_regs [8];
  bit tmr_init = 1'b0;
  always @(posedge clk) begin
    if (!tmr_init) begin
      for (int i = 0; i < 8; i++) tmr_regs[i] <= seed(i);
      tmr_init <= 1'b1;
    end else begin
      if (s_chipselect && !s_write_n && s_address < 3'd6) tmr_regs[s_address] <= s_writedata;
      if (s_chipselect && s_write_n) s_readdata <= (s_address < 3'd6) ? tmr_regs[s_address] : '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // strobe monitor: a chipselect pulse must never last two cycles
  always @(negedge clk) begin
    if (s_chipselect) begin
      chk("cs_single_cycle", 32'(prev_cs), 32'd0);
      cs_count <= cs_count + 1;
      if (!s_write_n && s_address == 3'd4) snap_count <= snap_count + 1;
    end
    prev_cs <= s_chipselect;
  end

  function automatic logic get_wait(input int m);
    return (m == 1) ? m1_waitrequest : m0_waitrequest;
  endfunction

  function automatic logic [DW-1:0] get_rdata(input int m);
    return (m == 1) ? m1_readdata : m0_readdata;
  endfunction

  task automatic start(input int m, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_addr[m] = a;
    m_wd[m]   = d;
    m_wr[m]   = wr;
    m_rd[m]   = ~wr;
  endtask

  // wait for the master's completion, then check the strobe it caused and the data it got
  task automatic finish_wait(input int m, input bit wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, output int lat);
    logic [4:0]    prev_snap;
    logic [DW-1:0] exp_rd;
    bit            got;
    lat = 0;
    got = 1'b0;
    prev_snap = '0;
    while (!got) begin
      @(negedge clk);
      lat++;
      if (!get_wait(m)) begin
        got = 1'b1;
        if (wr) begin
          chk($sformatf("m%0d_wr_strobe", m), 32'({s_chipselect, s_write_n, s_address, s_writedata}),
              32'({1'b1, 1'b0, a, d}));
          if (a < 3'd6) ref_mem[a] = d;
        end else begin
          exp_rd = (a < 3'd6) ? ref_mem[a] : '0;
          chk($sformatf("m%0d_rd_strobe", m), 32'(prev_snap), 32'({1'b1, 1'b1, a}));
          chk($sformatf("m%0d_rdata", m), 32'(get_rdata(m)), 32'(exp_rd));
          last_rd[m] = exp_rd;
        end
        chk($sformatf("m%0d_rdata_held", 1 - m), 32'(get_rdata(1 - m)), 32'(last_rd[1 - m]));
        order.push_back(m);
      end else if (lat >= 60) begin
        chk($sformatf("m%0d_timeout", m), 32'(get_wait(m)), 32'd0);
        got = 1'b1;
      end
      prev_snap = {s_chipselect, s_write_n, s_address};
    end
    m_rd[m] = 1'b0;
    m_wr[m] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    last_rd[0] = '0;
    last_rd[1] = '0;
    reset_n = 1'b1;
  endtask

  task automatic run_writes(input int m, input int n);
    int lat;
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = AW'($urandom_range(5));
      d = DW'($urandom);
      start(m, 1'b1, a, d);
      finish_wait(m, 1'b1, a, d, lat);
    end
  endtask

  task automatic run_random(input int m, input int n);
    int lat;
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      bit            wr;
      repeat ($urandom_range(3)) @(negedge clk);
      a  = AW'($urandom_range(7));
      d  = DW'($urandom);
      wr = 1'($urandom_range(1));
      start(m, wr, a, d);
      finish_wait(m, wr, a, d, lat);
    end
  endtask

  initial begin
    int lat;
    int base;
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = '0; m_rd[i] = 1'b0; m_wr[i] = 1'b0; m_wd[i] = '0; last_rd[i] = '0;
    end
    for (int i = 0; i < 8; i++) ref_mem[i] = seed(i);

    repeat (2) @(negedge clk);
    chk("reset_slave", 32'({s_chipselect, s_write_n, s_address, s_writedata}), 32'({1'b0, 1'b1, 3'd0, 16'd0}));
    chk("reset_rdata", 32'({m0_readdata, m1_readdata}), 32'd0);
    reset_n = 1'b1;

    // lone write to control
    start(0, 1'b1, 3'd1, 16'h0006);
    finish_wait(0, 1'b1, 3'd1, 16'h0006, lat);
    chk("t1_wr_latency", 32'(lat), 32'd1);

    // lone read of status
    @(negedge clk);
    start(1, 1'b0, 3'd0, 16'h0000);
    finish_wait(1, 1'b0, 3'd0, 16'h0000, lat);
    chk("t2_rd_latency", 32'(lat), 32'd2);
    chk("t2_status", 32'(m1_readdata), 32'h0002);

    // both writing continuously from reset: strict alternation starting with m0
    do_reset();
    order.delete();
    fork
      run_writes(0, 4);
      run_writes(1, 4);
    join
    for (int i = 0; i < 8; i++) begin
      if (i < order.size()) chk($sformatf("t3_order%0d", i), 32'(order[i]), 32'(i % 2));
      else chk($sformatf("t3_missing%0d", i), 32'(order.size()), 32'd8);
    end

    // concurrent read and snapshot write on address 4
    @(negedge clk);
    #1 base = snap_count;
    fork
      begin
        start(0, 1'b0, 3'd4, 16'h0000);
        finish_wait(0, 1'b0, 3'd4, 16'h0000, lat);
      end
      begin
        int lat1;
        start(1, 1'b1, 3'd4, 16'h5a5a);
        finish_wait(1, 1'b1, 3'd4, 16'h5a5a, lat1);
      end
    join
    @(negedge clk);
    #1 chk("t4_snap_once", 32'(snap_count - base), 32'd1);

    // reset during the ISSUE cycle of a read
    @(negedge clk);
    start(0, 1'b0, 3'd0, 16'h0000);
    @(negedge clk);
    chk("t5_in_issue", 32'(s_chipselect), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_reset_slave", 32'({s_chipselect, s_write_n, s_address, s_writedata}), 32'({1'b0, 1'b1, 3'd0, 16'd0}));
    chk("t5_reset_rdata", 32'(m0_readdata), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t5_no_done", 32'({m0_waitrequest, s_chipselect}), 32'({1'b1, 1'b0}));
    end
    last_rd[0] = '0;
    last_rd[1] = '0;
    reset_n = 1'b1;
    finish_wait(0, 1'b0, 3'd0, 16'h0000, lat);
    chk("t5_reissue_latency", 32'(lat), 32'd2);

    // randomized contention
    @(negedge clk);
    #1 base = cs_count;
    fork
      run_random(0, 30);
      run_random(1, 30);
    join
    @(negedge clk);
    #1 chk("rand_strobe_count", 32'(cs_count - base), 32'd60);

    // interrupt routing
    @(negedge clk);
    start(1, 1'b1, 3'd1, 16'h0001);
    finish_wait(1, 1'b1, 3'd1, 16'h0001, lat);
    @(negedge clk);
    chk("t6_irq_idle", 32'({m0_irq, m1_irq}), 32'd0);
    s_irq = 1'b1;
    #1;
`ifdef SHARED_TIMER_IRQ_STEER_EN
    chk("t6_irq_steer", 32'({m0_irq, m1_irq}), 32'({1'b0, 1'b1}));
`else
    chk("t6_irq_copy", 32'({m0_irq, m1_irq}), 32'({1'b1, 1'b1}));
`endif
    s_irq = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
